// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares a single req/gnt/rvalid memory port between the instruction fetch
// stage and the load/store stage. One transaction is outstanding at a time;
// contention is resolved round-robin and each response is routed back to the
// requester that issued it. A flush marks an in-flight fetch as stale so that
// its response is swallowed while the memory side still completes normally.

module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,

  // fetch side
  input  logic                    instr_req_in,
  input  logic [ADDR_WIDTH-1:0]   instr_addr_in,
  output logic                    instr_gnt_out,
  output logic                    instr_rvalid_out,
  output logic [DATA_WIDTH-1:0]   instr_rdata_out,

  // load/store side
  input  logic                    data_req_in,
  input  logic                    data_we_in,
  input  logic [DATA_WIDTH/8-1:0] data_be_in,
  input  logic [ADDR_WIDTH-1:0]   data_addr_in,
  input  logic [DATA_WIDTH-1:0]   data_wdata_in,
  output logic                    data_gnt_out,
  output logic                    data_rvalid_out,
  output logic [DATA_WIDTH-1:0]   data_rdata_out,

  // pipeline control
  input  logic                    flush_in,

  // memory side
  output logic                    mem_req_out,
  output logic                    mem_we_out,
  output logic [DATA_WIDTH/8-1:0] mem_be_out,
  output logic [ADDR_WIDTH-1:0]   mem_addr_out,
  output logic [DATA_WIDTH-1:0]   mem_wdata_out,
  input  logic                    mem_gnt_in,
  input  logic                    mem_rvalid_in,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_in,

  output logic                    busy_out
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  // transaction phases
  localparam logic [1:0] IDLE = 2'd0;  // waiting for a requester
  localparam logic [1:0] REQ  = 2'd1;  // request presented, waiting for gnt
  localparam logic [1:0] RESP = 2'd2;  // accepted, waiting for rvalid

  // requester identity
  localparam logic OWNER_INSTR = 1'b0;
  localparam logic OWNER_DATA  = 1'b1;

  logic [1:0]            state;
  logic                  owner;       // requester of the current transaction
  logic                  last_owner;  // requester granted most recently
  logic                  discard;     // current fetch was flushed; drop its response

  logic                  lat_we;
  logic [BE_WIDTH-1:0]   lat_be;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;

  logic                  any_req;
  logic                  win_data;
  logic                  in_req;
  logic                  gnt_hit;
  logic                  resp_hit;
  logic                  owner_is_instr;
  logic                  owner_is_data;

  assign in_req         = (state == REQ);
  assign gnt_hit        = in_req && mem_gnt_in;
  assign resp_hit       = (state == RESP) && mem_rvalid_in;
  assign owner_is_instr = (owner == OWNER_INSTR);
  assign owner_is_data  = (owner == OWNER_DATA);

  // Round-robin pick: a lone requester wins outright; on contention the side
  // that was not granted last wins, so after reset (last = INSTR) DATA goes first.
  always_comb begin
    any_req  = instr_req_in || data_req_in;
    win_data = 1'b0;
    if (data_req_in && !instr_req_in) begin
      win_data = 1'b1;
    end else if (data_req_in && instr_req_in) begin
      win_data = (last_owner == OWNER_INSTR);
    end
  end

  // Transaction sequencing: arbitrate in IDLE, wait for gnt in REQ, wait for
  // rvalid in RESP. gnt/rvalid seen in any other phase are simply ignored.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state      <= IDLE;
      owner      <= OWNER_INSTR;
      last_owner <= OWNER_INSTR;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner <= win_data ? OWNER_DATA : OWNER_INSTR;
            state <= REQ;
          end
        end
        REQ: begin
          if (mem_gnt_in) begin
            last_owner <= owner;
            state      <= RESP;
          end
        end
        RESP: begin
          if (mem_rvalid_in) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Capture the winning request so the memory port stays stable while the
  // requester is free to move on. Fetches are always full-word reads.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      lat_we    <= 1'b0;
      lat_be    <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (state == IDLE && any_req) begin
      if (win_data) begin
        lat_we    <= data_we_in;
        lat_be    <= data_be_in;
        lat_addr  <= data_addr_in;
        lat_wdata <= data_wdata_in;
      end else begin
        lat_we    <= 1'b0;
        lat_be    <= '1;
        lat_addr  <= instr_addr_in;
        lat_wdata <= '0;
      end
    end
  end

  // Stale-fetch marker: set by a flush while a fetch is in flight, cleared when
  // that transaction's response arrives (which wins over a coincident flush).
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      discard <= 1'b0;
    end else if (resp_hit) begin
      discard <= 1'b0;
    end else if (flush_in && owner_is_instr && state != IDLE) begin
      discard <= 1'b1;
    end
  end

  // Memory request: the latched fields are driven only while requesting and
  // held there until the memory grants.
  always_comb begin
    mem_req_out   = in_req;
    mem_we_out    = 1'b0;
    mem_be_out    = '0;
    mem_addr_out  = '0;
    mem_wdata_out = '0;
    if (in_req) begin
      mem_we_out    = lat_we;
      mem_be_out    = lat_be;
      mem_addr_out  = lat_addr;
      mem_wdata_out = lat_wdata;
    end
  end

  // Grant fan-out: the memory's gnt goes to the owner in the same cycle; a
  // flushed fetch gets no grant since the fetch stage has already moved on.
  always_comb begin
    instr_gnt_out = gnt_hit && owner_is_instr && !discard;
    data_gnt_out  = gnt_hit && owner_is_data;
  end

  // Response fan-out: route rvalid/rdata to the owner combinationally. A fetch
  // response is dropped if the fetch was flushed earlier or is flushed now.
  always_comb begin
    instr_rvalid_out = resp_hit && owner_is_instr && !discard && !flush_in;
    data_rvalid_out  = resp_hit && owner_is_data;
    instr_rdata_out  = '0;
    data_rdata_out   = '0;
    if (instr_rvalid_out) begin
      instr_rdata_out = mem_rdata_in;
    end
    if (data_rvalid_out) begin
      data_rdata_out = mem_rdata_in;
    end
  end

  // Busy whenever a transaction is outstanding.
  always_comb begin
    busy_out = (state != IDLE);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by randomized
// traffic, every cycle compared against a transaction-level reference model.

module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n_in;
  logic          instr_req_in;
  logic [AW-1:0] instr_addr_in;
  logic          instr_gnt_out;
  logic          instr_rvalid_out;
  logic [DW-1:0] instr_rdata_out;
  logic          data_req_in;
  logic          data_we_in;
  logic [BW-1:0] data_be_in;
  logic [AW-1:0] data_addr_in;
  logic [DW-1:0] data_wdata_in;
  logic          data_gnt_out;
  logic          data_rvalid_out;
  logic [DW-1:0] data_rdata_out;
  logic          flush_in;
  logic          mem_req_out;
  logic          mem_we_out;
  logic [BW-1:0] mem_be_out;
  logic [AW-1:0] mem_addr_out;
  logic [DW-1:0] mem_wdata_out;
  logic          mem_gnt_in;
  logic          mem_rvalid_in;
  logic [DW-1:0] mem_rdata_in;
  logic          busy_out;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_in           (clk),
    .rst_n_in         (rst_n_in),
    .instr_req_in     (instr_req_in),
    .instr_addr_in    (instr_addr_in),
    .instr_gnt_out    (instr_gnt_out),
    .instr_rvalid_out (instr_rvalid_out),
    .instr_rdata_out  (instr_rdata_out),
    .data_req_in      (data_req_in),
    .data_we_in       (data_we_in),
    .data_be_in       (data_be_in),
    .data_addr_in     (data_addr_in),
    .data_wdata_in    (data_wdata_in),
    .data_gnt_out     (data_gnt_out),
    .data_rvalid_out  (data_rvalid_out),
    .data_rdata_out   (data_rdata_out),
    .flush_in         (flush_in),
    .mem_req_out      (mem_req_out),
    .mem_we_out       (mem_we_out),
    .mem_be_out       (mem_be_out),
    .mem_addr_out     (mem_addr_out),
    .mem_wdata_out    (mem_wdata_out),
    .mem_gnt_in       (mem_gnt_in),
    .mem_rvalid_in    (mem_rvalid_in),
    .mem_rdata_in     (mem_rdata_in),
    .busy_out         (busy_out)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one optional outstanding transaction record.
  bit            m_active;     // a transaction exists
  bit            m_granted;    // memory has accepted it
  bit            m_is_data;    // issued by the LSU
  bit            m_dropped;    // fetch flushed, response must vanish
  bit            m_last_data;  // most recent grant went to the LSU
  logic          m_we;
  logic [BW-1:0] m_be;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;

  // expected outputs for the current cycle
  logic          e_ig, e_irv, e_dg, e_drv, e_mreq, e_mwe, e_busy;
  logic [DW-1:0] e_ird, e_drd, e_mwdata;
  logic [BW-1:0] e_mbe;
  logic [AW-1:0] e_maddr;

  bit order_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active    = 1'b0;
    m_granted   = 1'b0;
    m_is_data   = 1'b0;
    m_dropped   = 1'b0;
    m_last_data = 1'b0;
  endtask

  task automatic model_outputs();
    e_ig = 0; e_irv = 0; e_dg = 0; e_drv = 0; e_mreq = 0; e_mwe = 0;
    e_ird = '0; e_drd = '0; e_mwdata = '0; e_mbe = '0; e_maddr = '0;
    e_busy = m_active;
    if (m_active && !m_granted) begin
      e_mreq = 1; e_mwe = m_we; e_mbe = m_be; e_maddr = m_addr; e_mwdata = m_wdata;
      if (mem_gnt_in) begin
        if (m_is_data) e_dg = 1;
        else if (!m_dropped) e_ig = 1;
      end
    end
    if (m_active && m_granted && mem_rvalid_in) begin
      if (m_is_data) begin
        e_drv = 1; e_drd = mem_rdata_in;
      end else if (!m_dropped && !flush_in) begin
        e_irv = 1; e_ird = mem_rdata_in;
      end
    end
  endtask

  task automatic model_advance();
    if (!rst_n_in) return;
    if (!m_active) begin
      if (instr_req_in || data_req_in) begin
        m_is_data = data_req_in && (!instr_req_in || !m_last_data);
        if (m_is_data) begin
          m_we = data_we_in; m_be = data_be_in; m_addr = data_addr_in; m_wdata = data_wdata_in;
        end else begin
          m_we = 1'b0; m_be = '1; m_addr = instr_addr_in; m_wdata = '0;
        end
        m_active = 1; m_granted = 0; m_dropped = 0;
      end
    end else begin
      if (flush_in && !m_is_data) m_dropped = 1;
      if (!m_granted) begin
        if (mem_gnt_in) begin
          m_granted = 1; m_last_data = m_is_data;
        end
      end else if (mem_rvalid_in) begin
        m_active = 0;
      end
    end
  endtask

  // Inputs are already applied; let them settle and compare every output.
  task automatic settle_and_check();
    #1;
    if (!rst_n_in) model_reset();
    model_outputs();
    chk("instr_gnt",    instr_gnt_out,    e_ig);
    chk("instr_rvalid", instr_rvalid_out, e_irv);
    chk("instr_rdata",  instr_rdata_out,  e_ird);
    chk("data_gnt",     data_gnt_out,     e_dg);
    chk("data_rvalid",  data_rvalid_out,  e_drv);
    chk("data_rdata",   data_rdata_out,   e_drd);
    chk("mem_req",      mem_req_out,      e_mreq);
    chk("mem_we",       mem_we_out,       e_mwe);
    chk("mem_be",       mem_be_out,       e_mbe);
    chk("mem_addr",     mem_addr_out,     e_maddr);
    chk("mem_wdata",    mem_wdata_out,    e_mwdata);
    chk("busy",         busy_out,         e_busy);
  endtask

  task automatic tick();
    @(posedge clk);
    model_advance();
    @(negedge clk);
  endtask

  task automatic step();
    settle_and_check();
    tick();
  endtask

  task automatic quiet_inputs();
    instr_req_in = 0; instr_addr_in = '0;
    data_req_in = 0; data_we_in = 0; data_be_in = '0; data_addr_in = '0; data_wdata_in = '0;
    flush_in = 0; mem_gnt_in = 0; mem_rvalid_in = 0; mem_rdata_in = '0;
  endtask

  initial begin
    quiet_inputs();
    rst_n_in = 0;
    model_reset();

    // reset state
    step();
    step();
    chk("reset_busy", busy_out, 1'b0);
    rst_n_in = 1;
    step();

    // single fetch
    instr_req_in = 1; instr_addr_in = 32'h100;
    step();
    settle_and_check();
    chk("t1_addr", mem_addr_out, 32'h100);
    chk("t1_we",   mem_we_out, 1'b0);
    chk("t1_req",  mem_req_out, 1'b1);
    tick();
    mem_gnt_in = 1;
    settle_and_check();
    chk("t1_gnt", instr_gnt_out, 1'b1);
    tick();
    instr_req_in = 0; mem_gnt_in = 0;
    mem_rvalid_in = 1; mem_rdata_in = 32'hDEADBEEF;
    settle_and_check();
    chk("t1_rvalid",  instr_rvalid_out, 1'b1);
    chk("t1_rdata",   instr_rdata_out, 32'hDEADBEEF);
    chk("t1_drvalid", data_rvalid_out, 1'b0);
    tick();
    quiet_inputs();
    step();

    // contention: both held high for four transactions
    instr_req_in = 1; instr_addr_in = 32'h400;
    data_req_in = 1; data_addr_in = 32'h800;
    mem_gnt_in = 1; mem_rvalid_in = 1; mem_rdata_in = 32'hA5A5_0001;
    for (int i = 0; i < 12; i++) begin
      settle_and_check();
      if (data_gnt_out) order_q.push_back(1'b1);
      if (instr_gnt_out) order_q.push_back(1'b0);
      tick();
    end
    quiet_inputs();
    chk("t2_ngrants", order_q.size(), 4);
    for (int i = 0; i < order_q.size(); i++)
      chk("t2_order", order_q[i], (i % 2 == 0));
    step();

    // data write with grant delayed by three cycles
    data_req_in = 1; data_we_in = 1; data_addr_in = 32'h2000;
    data_wdata_in = 32'h12345678; data_be_in = 4'b0011;
    step();
    for (int i = 0; i < 4; i++) begin
      mem_gnt_in = (i == 3);
      settle_and_check();
      chk("t3_addr",  mem_addr_out, 32'h2000);
      chk("t3_wdata", mem_wdata_out, 32'h12345678);
      chk("t3_be",    mem_be_out, 4'b0011);
      chk("t3_we",    mem_we_out, 1'b1);
      chk("t3_gnt",   data_gnt_out, (i == 3));
      tick();
    end
    quiet_inputs();
    mem_rvalid_in = 1;
    settle_and_check();
    chk("t3_rvalid", data_rvalid_out, 1'b1);
    tick();
    quiet_inputs();
    step();

    // fetch flushed in RESP before its response
    instr_req_in = 1; instr_addr_in = 32'h300;
    step();
    mem_gnt_in = 1;
    step();
    quiet_inputs();
    flush_in = 1;
    step();
    flush_in = 0; mem_rvalid_in = 1; mem_rdata_in = 32'h0BAD0BAD;
    settle_and_check();
    chk("t4_dropped", instr_rvalid_out, 1'b0);
    chk("t4_busy",    busy_out, 1'b1);
    tick();
    quiet_inputs();
    settle_and_check();
    chk("t4_idle", busy_out, 1'b0);
    tick();
    instr_req_in = 1; instr_addr_in = 32'h304;
    step();
    mem_gnt_in = 1;
    settle_and_check();
    chk("t4_gnt2", instr_gnt_out, 1'b1);
    tick();
    quiet_inputs();
    mem_rvalid_in = 1; mem_rdata_in = 32'h600D600D;
    settle_and_check();
    chk("t4_rvalid2", instr_rvalid_out, 1'b1);
    chk("t4_rdata2",  instr_rdata_out, 32'h600D600D);
    tick();
    quiet_inputs();

    // flush while the LSU owns the port
    data_req_in = 1; data_addr_in = 32'h3000; data_be_in = 4'hF;
    step();
    flush_in = 1;
    step();
    flush_in = 0; mem_gnt_in = 1;
    settle_and_check();
    chk("t5_gnt", data_gnt_out, 1'b1);
    tick();
    quiet_inputs();
    mem_rvalid_in = 1; mem_rdata_in = 32'hCAFEF00D;
    settle_and_check();
    chk("t5_rvalid", data_rvalid_out, 1'b1);
    chk("t5_rdata",  data_rdata_out, 32'hCAFEF00D);
    tick();
    quiet_inputs();

    // reset while waiting for a response, late rvalid afterwards
    instr_req_in = 1; instr_addr_in = 32'h500;
    step();
    mem_gnt_in = 1;
    step();
    quiet_inputs();
    rst_n_in = 0;
    settle_and_check();
    chk("t6_busy_rst", busy_out, 1'b0);
    tick();
    rst_n_in = 1;
    mem_rvalid_in = 1; mem_rdata_in = 32'h11112222;
    settle_and_check();
    chk("t6_late_rvalid", instr_rvalid_out, 1'b0);
    chk("t6_late_busy",   busy_out, 1'b0);
    chk("t6_late_rdata",  instr_rdata_out, 32'h0);
    tick();
    quiet_inputs();
    step();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (!instr_req_in || e_ig || flush_in || !rst_n_in) begin
        instr_req_in  = 1'($urandom_range(0, 1));
        instr_addr_in = $urandom;
      end
      if (!data_req_in || e_dg || !rst_n_in) begin
        data_req_in   = 1'($urandom_range(0, 1));
        data_we_in    = 1'($urandom_range(0, 1));
        data_be_in    = BW'($urandom);
        data_addr_in  = $urandom;
        data_wdata_in = $urandom;
      end
      flush_in      = ($urandom_range(0, 6) == 0);
      mem_gnt_in    = 1'($urandom_range(0, 1));
      mem_rvalid_in = 1'($urandom_range(0, 1));
      mem_rdata_in  = $urandom;
      rst_n_in      = ($urandom_range(0, 149) != 0);
      step();
    end

    quiet_inputs();
    rst_n_in = 1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one req/gnt/rvalid memory port between the instruction fetch stage and the data (load/store) stage.
- Allows one outstanding transaction at a time. Uses round-robin arbitration on contention and routes each response back to the requester that issued it.
- On a pipeline flush, discards an in-flight instruction response.
- Sits between the fetch and LSU stages and the single-ported memory/bus interface.

Parameters:
- ADDR_WIDTH, 32, width of all address buses
- DATA_WIDTH, 32, width of all data buses; byte-enable width is DATA_WIDTH/8

Ports:
- clk_in  in  1  clock; all state updates on rising edge
- rst_n_in  in  1  asynchronous active-low reset
- instr_req_in  in  1  fetch request; held with address until instr_gnt_out
- instr_addr_in  in  ADDR_WIDTH  fetch address
- instr_gnt_out  out  1  fetch request accepted by memory (1-cycle pulse)
- instr_rvalid_out  out  1  fetch response valid (1-cycle pulse)
- instr_rdata_out  out  DATA_WIDTH  fetch response data
- data_req_in  in  1  data request; held with all fields until data_gnt_out
- data_we_in  in  1  1 = write, 0 = read
- data_be_in  in  DATA_WIDTH/8  byte enables
- data_addr_in  in  ADDR_WIDTH  data address
- data_wdata_in  in  DATA_WIDTH  write data
- data_gnt_out  out  1  data request accepted (1-cycle pulse)
- data_rvalid_out  out  1  data response valid (also pulses for writes)
- data_rdata_out  out  DATA_WIDTH  read data
- flush_in  in  1  branch mispredict/flush; discards pending instruction response
- mem_req_out  out  1  memory request
- mem_we_out  out  1  memory write enable
- mem_be_out  out  DATA_WIDTH/8  memory byte enables
- mem_addr_out  out  ADDR_WIDTH  memory address
- mem_wdata_out  out  DATA_WIDTH  memory write data
- mem_gnt_in  in  1  memory accepts request this cycle
- mem_rvalid_in  in  1  memory response valid
- mem_rdata_in  in  DATA_WIDTH  memory response data
- busy_out  out  1  high whenever state is not IDLE

Behaviour:
- Clocking and reset: one clock (clk_in). Reset rst_n_in is asynchronous, active-low.
- Reset effects: state = IDLE, owner = INSTR, last_owner = INSTR, discard = 0. Latched request fields are cleared to 0. All outputs are 0.
- Reset mid-transaction: abandons the transaction; a late mem_rvalid_in is ignored because state is IDLE.
- FSM has three states: IDLE, REQ, RESP.
- IDLE, arbitration:
  - Only instr_req_in high: winner = INSTR.
  - Only data_req_in high: winner = DATA.
  - Both high: winner is the opposite of last_owner, so the first contention after reset goes to DATA.
  - On the edge: latch the winner into owner and latch its addr/we/be/wdata. Instruction requests latch we = 0, be = all ones, wdata = 0. Go to REQ.
  - No request: stay in IDLE.
- REQ:
  - mem_req_out = 1; mem_* outputs are driven from the latched fields.
  - mem_gnt_in = 1: the owner's gnt_out = 1 in that same cycle (combinational), except instr_gnt_out is suppressed while discard = 1. Set last_owner = owner and go to RESP.
  - mem_gnt_in = 0: hold all outputs stable; the request is never retracted.
- RESP:
  - mem_req_out = 0.
  - mem_rvalid_in = 1: if owner = DATA, data_rvalid_out = 1 and data_rdata_out = mem_rdata_in, combinationally in the same cycle. If owner = INSTR and discard = 0, route to the instr_* outputs the same way. If discard = 1, drop the response.
  - On mem_rvalid_in: clear discard and go to IDLE.
- Latency:
  - Request accepted in IDLE at edge N → mem_req_out high from cycle N+1.
  - Minimum turnaround, with gnt in the first REQ cycle and rvalid in the first RESP cycle: a new arbitration every 3 cycles.
- Flush:
  - flush_in with owner = INSTR in REQ or RESP sets discard = 1; the transaction still completes on the memory side.
  - flush_in in IDLE, or with owner = DATA, has no effect.
  - flush_in in the same cycle as mem_rvalid_in in RESP: the response is dropped.
- Protocol errors: mem_rvalid_in in IDLE or REQ is ignored. mem_gnt_in outside REQ is ignored.
- Idle outputs: rdata outputs are 0 when the matching rvalid is 0. mem_* fields are 0 outside REQ.

Test Plan:
- Reset, then instr_req_in = 1, instr_addr_in = 0x100, mem_gnt_in one cycle after mem_req_out, mem_rvalid_in next cycle with 0xDEADBEEF → mem_addr_out = 0x100, mem_we_out = 0, instr_gnt_out pulses once, instr_rvalid_out = 1 with 0xDEADBEEF, data_* stays 0.
- instr_req_in and data_req_in both held high for 4 transactions → grant order DATA, INSTR, DATA, INSTR; each rvalid reaches only its owner.
- Data write: addr 0x2000, wdata 0x12345678, be 4'b0011, mem_gnt_in delayed 3 cycles → mem_* fields stay stable for all 4 REQ cycles; data_gnt_out pulses on the 4th; data_rvalid_out pulses on the response.
- Instruction transaction with flush_in pulsed in RESP before mem_rvalid_in → instr_rvalid_out stays 0; busy_out falls after the rvalid; the next instr_req_in is served normally.
- flush_in in REQ with owner = DATA → data_gnt_out and data_rvalid_out are delivered normally.
- rst_n_in asserted in RESP, then a mem_rvalid_in arrives after reset release → all outputs 0, state IDLE, response ignored.
